// File: rtl/round_pkg.sv
// ----------------------------------------------------------------------------
// round_pkg
// Shared types for the round counter: FSM state encoding, counting-mode
// encoding and small mode-decode helpers.
// ----------------------------------------------------------------------------
package round_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE_UP_WRAP    = 2'b00,
        MODE_DOWN_WRAP  = 2'b01,
        MODE_UP_ONESHOT = 2'b10,
        MODE_RSVD       = 2'b11   // decodes as up-wrap
    } mode_t;

    // Only down-wrap counts downward; the reserved code falls through to up-wrap.
    function automatic logic is_down(input mode_t m);
        return (m == MODE_DOWN_WRAP);
    endfunction

    function automatic logic is_oneshot(input mode_t m);
        return (m == MODE_UP_ONESHOT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used to count terminal events within one run.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset (count -> 0)
//   i_clr   - synchronous clear, wins over i_inc
//   i_inc   - increment by one, holding at all-ones
//   o_count - registered count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int WRAP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [WRAP_W-1:0] o_count
);

    logic [WRAP_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !(&r_count)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/round_counter_fsm.sv
// ----------------------------------------------------------------------------
// round_counter_fsm
// Two-state (IDLE/RUN) round counter. A run is started from IDLE, latching
// the terminal limit and counting mode; each E in RUN advances one round.
// Reaching the terminal value produces a one-cycle tc pulse and bumps a
// saturating wrap count; oneshot runs also pulse done and return to IDLE.
// abort ends a run at once with no tc/done.
// Ports:
//   clk   - rising-edge clock
//   R     - asynchronous active-low reset
//   start - begin a run (IDLE only)
//   E     - advance one round (RUN only)
//   abort - terminate the run, highest priority
//   mode  - 00 up-wrap, 01 down-wrap, 10 up-oneshot, 11 as 00
//   data  - terminal limit, latched on accepted start
//   ROUND - current round value
//   tc    - terminal-count pulse
//   busy  - high while in RUN
//   done  - oneshot completion pulse
//   wraps - saturating terminal-event count for the current run
// ----------------------------------------------------------------------------
module round_counter_fsm
    import round_pkg::*;
#(
    parameter int SIZE   = 4,   // 2..16
    parameter int WRAP_W = 4    // 1..16
) (
    input  logic              clk,
    input  logic              R,
    input  logic              start,
    input  logic              E,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [SIZE-1:0]   data,
    output logic [SIZE-1:0]   ROUND,
    output logic              tc,
    output logic              busy,
    output logic              done,
    output logic [WRAP_W-1:0] wraps
);

    state_t          r_state;
    mode_t           r_mode;
    logic [SIZE-1:0] r_limit;
    logic [SIZE-1:0] r_round;
    logic            r_tc;
    logic            r_done;

    logic            w_down;
    logic            w_oneshot;
    logic            w_terminal;
    logic            w_accept;
    logic            w_wrap_inc;
    logic [SIZE-1:0] w_start_round;

    assign w_down    = is_down(r_mode);
    assign w_oneshot = is_oneshot(r_mode);

    // Down-wrap terminates at zero, every up mode at the latched limit.
    // With a zero limit the up test is true on every E, so ROUND stays 0.
    assign w_terminal = w_down ? (r_round == '0) : (r_round == r_limit);

    assign w_accept      = (r_state == ST_IDLE) && start && !abort;
    assign w_start_round = (mode_t'(mode) == MODE_DOWN_WRAP) ? data : '0;

    // abort suppresses the wrap increment along with tc/done.
    assign w_wrap_inc = (r_state == ST_RUN) && !abort && E && w_terminal;

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_UP_WRAP;
            r_limit <= '0;
            r_round <= '0;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // Pulses last exactly one cycle.
            r_tc   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // ROUND holds here so a finished oneshot keeps its value.
                    if (w_accept) begin
                        r_limit <= data;
                        r_mode  <= mode_t'(mode);
                        r_round <= w_start_round;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_round <= '0;
                    end else if (E) begin
                        if (w_terminal) begin
                            r_tc <= 1'b1;
                            if (w_oneshot) begin
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                            end else if (w_down) begin
                                r_round <= r_limit;
                            end else begin
                                r_round <= '0;
                            end
                        end else if (w_down) begin
                            r_round <= r_round - 1'b1;
                        end else begin
                            r_round <= r_round + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sat_counter #(
        .WRAP_W (WRAP_W)
    ) u_wraps (
        .clk     (clk),
        .rst_n   (R),
        .i_clr   (w_accept),
        .i_inc   (w_wrap_inc),
        .o_count (wraps)
    );

    assign ROUND = r_round;
    assign tc    = r_tc;
    assign done  = r_done;
    assign busy  = (r_state == ST_RUN);

endmodule

// File: tb/tb_round_counter_fsm.sv
// ----------------------------------------------------------------------------
// tb_round_counter_fsm
// Table of {inputs, expected outputs} records applied one per clock; the
// expected record is queued when driven and popped when the outputs are
// sampled after the edge. The asynchronous reset sequence is hand-written.
// ----------------------------------------------------------------------------
module tb_round_counter_fsm;

    localparam int SIZE   = 4;
    localparam int WRAP_W = 2;

    logic              clk   = 1'b0;
    logic              R     = 1'b0;
    logic              start = 1'b0;
    logic              E     = 1'b0;
    logic              abort = 1'b0;
    logic [1:0]        mode  = 2'b00;
    logic [SIZE-1:0]   data  = '0;
    logic [SIZE-1:0]   ROUND;
    logic              tc;
    logic              busy;
    logic              done;
    logic [WRAP_W-1:0] wraps;

    round_counter_fsm #(
        .SIZE   (SIZE),
        .WRAP_W (WRAP_W)
    ) dut (
        .clk   (clk),
        .R     (R),
        .start (start),
        .E     (E),
        .abort (abort),
        .mode  (mode),
        .data  (data),
        .ROUND (ROUND),
        .tc    (tc),
        .busy  (busy),
        .done  (done),
        .wraps (wraps)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              st;
        logic              e;
        logic              ab;
        logic [1:0]        md;
        logic [SIZE-1:0]   dt;
        logic [SIZE-1:0]   rnd;
        logic              tc;
        logic              busy;
        logic              done;
        logic [WRAP_W-1:0] wr;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(int st, int e, int ab, int md, int dt,
                                int rnd, int t, int b, int d, int wr);
        vec_t v;
        v.st   = 1'(st);
        v.e    = 1'(e);
        v.ab   = 1'(ab);
        v.md   = 2'(md);
        v.dt   = SIZE'(dt);
        v.rnd  = SIZE'(rnd);
        v.tc   = 1'(t);
        v.busy = 1'(b);
        v.done = 1'(d);
        v.wr   = WRAP_W'(wr);
        return v;
    endfunction

    task automatic add(int st, int e, int ab, int md, int dt,
                       int rnd, int t, int b, int d, int wr);
        tbl.push_back(mk(st, e, ab, md, dt, rnd, t, b, d, wr));
    endtask

    task automatic check(string nm, vec_t x);
        n_cmp++;
        if ({ROUND, tc, busy, done, wraps} !== {x.rnd, x.tc, x.busy, x.done, x.wr}) begin
            n_bad++;
            $display("FAIL %s: got ROUND=%0d tc=%0b busy=%0b done=%0b wraps=%0d, want ROUND=%0d tc=%0b busy=%0b done=%0b wraps=%0d",
                     nm, ROUND, tc, busy, done, wraps, x.rnd, x.tc, x.busy, x.done, x.wr);
        end
    endtask

    task automatic apply(vec_t v, string nm);
        vec_t x;
        start = v.st;
        E     = v.e;
        abort = v.ab;
        mode  = v.md;
        data  = v.dt;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        check(nm, x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // inputs          start E ab md dt | ROUND tc busy done wraps
        // up-wrap, limit 3; start ignored in RUN; abort keeps wraps
        add(1,0,0,0,3,  0,0,1,0,0);
        add(0,1,0,0,3,  1,0,1,0,0);
        add(0,1,0,0,3,  2,0,1,0,0);
        add(0,1,0,0,3,  3,0,1,0,0);
        add(0,1,0,0,3,  0,1,1,0,1);
        add(0,0,0,0,3,  0,0,1,0,1);
        add(1,0,0,1,9,  0,0,1,0,1);
        add(0,1,0,0,3,  1,0,1,0,1);
        add(0,0,1,0,3,  0,0,0,0,1);
        // down-wrap, limit 2; mode/data garbage during RUN; wraps saturates
        add(1,0,0,1,2,  2,0,1,0,0);
        add(0,1,0,2,15, 1,0,1,0,0);
        add(0,1,0,2,15, 0,0,1,0,0);
        add(0,1,0,0,7,  2,1,1,0,1);
        add(0,1,0,0,7,  1,0,1,0,1);
        add(0,1,0,0,7,  0,0,1,0,1);
        add(0,1,0,0,7,  2,1,1,0,2);
        add(0,1,0,0,7,  1,0,1,0,2);
        add(0,1,0,0,7,  0,0,1,0,2);
        add(0,1,0,0,7,  2,1,1,0,3);
        add(0,1,0,0,7,  1,0,1,0,3);
        add(0,1,0,0,7,  0,0,1,0,3);
        add(0,1,0,0,7,  2,1,1,0,3);
        add(0,0,1,0,0,  0,0,0,0,3);
        // up-oneshot, limit 5: six E pulses, then E ignored in IDLE
        add(1,0,0,2,5,  0,0,1,0,0);
        add(0,1,0,2,5,  1,0,1,0,0);
        add(0,0,0,2,5,  1,0,1,0,0);
        add(0,1,0,2,5,  2,0,1,0,0);
        add(0,1,0,2,5,  3,0,1,0,0);
        add(0,1,0,2,5,  4,0,1,0,0);
        add(0,1,0,2,5,  5,0,1,0,0);
        add(0,1,0,2,5,  5,1,0,1,1);
        add(0,1,0,2,5,  5,0,0,0,1);
        add(0,1,0,2,5,  5,0,0,0,1);
        add(0,0,0,2,5,  5,0,0,0,1);
        // reserved mode as up-wrap, limit 0: terminal on every E
        add(1,0,0,3,0,  0,0,1,0,0);
        add(0,1,0,3,0,  0,1,1,0,1);
        add(0,1,0,3,0,  0,1,1,0,2);
        add(0,1,0,3,0,  0,1,1,0,3);
        add(0,1,0,3,0,  0,1,1,0,3);
        add(0,1,0,3,0,  0,1,1,0,3);
        add(0,1,0,3,0,  0,1,1,0,3);
        add(0,0,0,3,0,  0,0,1,0,3);
        add(1,0,1,0,5,  0,0,0,0,3);
        // start with abort in IDLE is refused
        add(1,0,1,0,7,  0,0,0,0,3);
        add(0,0,0,0,7,  0,0,0,0,3);
        // abort on the terminal cycle, up-wrap then oneshot
        add(1,0,0,0,3,  0,0,1,0,0);
        add(0,1,0,0,3,  1,0,1,0,0);
        add(0,1,0,0,3,  2,0,1,0,0);
        add(0,1,0,0,3,  3,0,1,0,0);
        add(0,1,1,0,3,  0,0,0,0,0);
        add(1,0,0,2,1,  0,0,1,0,0);
        add(0,1,0,2,1,  1,0,1,0,0);
        add(0,1,1,2,1,  0,0,0,0,0);

        // Reset state, before any clock edge
        #2;
        check("reset_initial", mk(0,0,0,0,0, 0,0,0,0,0));
        @(negedge clk);
        R = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_idle", mk(0,0,0,0,0, 0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-run, between clock edges
        apply(mk(1,0,0,0,1, 0,0,1,0,0), "ar_start");
        apply(mk(0,1,0,0,1, 1,0,1,0,0), "ar_e1");
        apply(mk(0,1,0,0,1, 0,1,1,0,1), "ar_term");
        apply(mk(0,1,0,0,1, 1,0,1,0,1), "ar_e2");
        #2;
        R = 1'b0;
        #1;
        check("ar_async_clear", mk(0,0,0,0,0, 0,0,0,0,0));
        start = 1'b1;
        E     = 1'b1;
        @(posedge clk);
        #1;
        check("ar_held_low", mk(0,0,0,0,0, 0,0,0,0,0));
        start = 1'b0;
        E     = 1'b0;
        @(negedge clk);
        #2;
        R = 1'b1;
        apply(mk(1,0,0,1,4, 4,0,1,0,0), "ar_restart");
        apply(mk(0,1,0,1,4, 3,0,1,0,0), "ar_restart_e");
        apply(mk(0,0,1,1,4, 0,0,0,0,0), "ar_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/round_counter_fsm.md
ROUND_COUNTER_FSM -- requirements
Module: round_counter_fsm

Interface
REQ-001 SHALL have parameter SIZE, default 4, giving the round counter and limit width in bits (2..16).
REQ-002 SHALL have parameter WRAP_W, default 4, giving the wrap-count width in bits (1..16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port R, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begin a run; sampled only in IDLE.
REQ-006 SHALL have port E, input, 1 bit: advance by one round; sampled only in RUN.
REQ-007 SHALL have port abort, input, 1 bit: terminate the run immediately.
REQ-008 SHALL have port mode, input, 2 bits: 00 up-wrap, 01 down-wrap, 10 up-oneshot, 11 reserved (treated as 00).
REQ-009 SHALL have port data, input, SIZE bits: terminal limit; sampled only on accepted start.
REQ-010 SHALL have port ROUND, output, SIZE bits: current round value.
REQ-011 SHALL have port tc, output, 1 bit: one-cycle terminal-count pulse.
REQ-012 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a oneshot run completes.
REQ-014 SHALL have port wraps, output, WRAP_W bits: terminal events in the current run, saturating.

Function
REQ-015 SHALL implement FSM states IDLE and RUN; all outputs registered.
REQ-016 In IDLE, start=1 and abort=0 SHALL latch data into limit_q and mode into mode_q, clear wraps, and enter RUN next cycle.
REQ-017 On the start cycle, ROUND SHALL load 0 for up modes and data for down-wrap.
REQ-018 start in RUN SHALL be ignored; changes to data or mode during RUN SHALL have no effect.
REQ-019 In RUN with E=0, ROUND, tc=0 and wraps SHALL hold.
REQ-020 Up modes, E=1, ROUND!=limit_q: ROUND SHALL increment by 1.
REQ-021 Down-wrap, E=1, ROUND!=0: ROUND SHALL decrement by 1.
REQ-022 Terminal event: E=1 with ROUND==limit_q (up) or ROUND==0 (down). tc SHALL be 1 the next cycle only, and wraps SHALL increment, holding at all-ones.
REQ-023 On terminal in up-wrap, ROUND SHALL load 0; in down-wrap, ROUND SHALL load limit_q; the FSM SHALL stay in RUN.
REQ-024 On terminal in up-oneshot, ROUND SHALL hold limit_q, done SHALL pulse together with tc, and the FSM SHALL return to IDLE.
REQ-025 With limit_q=0, every E=1 in RUN SHALL be a terminal event with ROUND staying 0.
REQ-026 abort=1 in RUN SHALL force IDLE next cycle, clear ROUND, and produce no tc or done; wraps SHALL hold its value.
REQ-027 abort=1 together with a terminal event SHALL take priority: no tc, no done.
REQ-028 abort=1 with start=1 in IDLE SHALL leave the FSM in IDLE.
REQ-029 ROUND SHALL hold in IDLE after a oneshot completion until the next accepted start.
REQ-030 busy SHALL equal (state==RUN).

Reset
REQ-031 R=0 SHALL asynchronously force IDLE with ROUND=0, tc=0, busy=0, done=0, wraps=0, limit_q=0, mode_q=00.
REQ-032 R asserted mid-run SHALL discard the run without emitting tc or done; the block SHALL resume on the first clk edge after R returns high.

Structure
REQ-033 State encodings and mode constants SHALL reside in a shared package, round_pkg.
REQ-034 The block SHALL be one module; the saturating wrap counter MAY be a sub-module, sat_counter (parameter WRAP_W).

Verification
REQ-035 Up-wrap, data=3, E held high: ROUND runs 0,1,2,3,0; tc pulses the cycle after ROUND=3; wraps=1.
REQ-036 Down-wrap, data=2, E held high: ROUND runs 2,1,0,2; tc pulses once per wrap; after 3 wraps, wraps=3.
REQ-037 Up-oneshot, data=5: after 6 E pulses, tc=done=1 for one cycle, busy=0, ROUND holds 5; further E pulses cause no change.
REQ-038 WRAP_W=2, data=0, E high for 6 cycles: tc pulses 6 times and wraps saturates at 3.
REQ-039 abort asserted on the same cycle as a terminal event (up-wrap, data=3, ROUND=3, E=1): no tc, ROUND=0, state IDLE.
REQ-040 R pulsed low mid-run between clock edges: outputs reach reset values immediately without a clock; start after R goes high begins a clean run.
